// File: rtl/aoc_pkg.sv
// Shared definitions for the puzzle solvers and their result printer.
package aoc_pkg;

   // Result printer sequencing
   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      SKIP,
      EMIT,
      NEWLINE,
      DONE
   } tx_state_t;

   // ASCII constants; the solvers parse the same line terminator
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Map a BCD digit (0..9) onto its ASCII character
   function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
      return ASCII_0 + {4'h0, d};
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more would exceed 9 once
// doubled, so it is pre-biased by 3 to carry correctly into the next digit.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Conditional +3 correction
   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/result_ascii_tx.sv
// Captures a solver answer, converts it to decimal and streams it as ASCII
// (most significant digit first, no leading zeros) followed by a newline.
module result_ascii_tx
   import aoc_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned DIGITS = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic [7:0]       out_byte,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
   localparam logic [IW-1:0] TOP_IDX    = IW'(DIGITS - 1);

   tx_state_t           state;
   logic [WIDTH-1:0]    bin_q;
   logic [BW-1:0]       bcd_q;
   logic [BW-1:0]       bcd_adj;
   logic [BW+WIDTH-1:0] shifted;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       idx_dec;
   logic [3:0]          cur_digit;
   logic [3:0]          next_digit;

   // Per-digit +3 correction ahead of each shift
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
         .din  (bcd_q[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   // One double-dabble step: corrected BCD and remaining binary shift left together
   assign shifted = {bcd_adj, bin_q} << 1;
   assign idx_dec = idx - 1'b1;

   // Digit mux: the digit under examination and the next lower one
   always_comb begin
      cur_digit  = 4'h0;
      next_digit = 4'h0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx == IW'(i)) begin
            cur_digit = bcd_q[4*i +: 4];
         end
         if (idx_dec == IW'(i)) begin
            next_digit = bcd_q[4*i +: 4];
         end
      end
   end

   // Sequencer with registered handshake and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt       <= '0;
         idx       <= '0;
         out_byte  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  bin_q <= in_data;
                  bcd_q <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CONVERT;
               end
            end
            CONVERT: begin
               bcd_q <= shifted[BW+WIDTH-1:WIDTH];
               bin_q <= shifted[WIDTH-1:0];
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_SHIFT) begin
                  idx   <= TOP_IDX;
                  state <= SKIP;
               end
            end
            SKIP: begin
               // Suppress leading zeros, but always print the units digit
               if (cur_digit != 4'h0 || idx == '0) begin
                  out_byte  <= digit_to_ascii(cur_digit);
                  out_valid <= 1'b1;
                  state     <= EMIT;
               end else begin
                  idx <= idx_dec;
               end
            end
            EMIT: begin
               // out_valid is always high here, so out_ready alone marks a transfer
               if (out_ready) begin
                  if (idx != '0) begin
                     idx      <= idx_dec;
                     out_byte <= digit_to_ascii(next_digit);
                  end else begin
                     out_byte <= ASCII_LF;
                     out_last <= 1'b1;
                     state    <= NEWLINE;
                  end
               end
            end
            NEWLINE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // One answer per reset; everything else is ignored
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_ascii_tx.sv
// Self-checking bench for result_ascii_tx: table of answers with expected text
// and first-byte latency, a byte scoreboard queue, plus reset and done corners.
module tb_result_ascii_tx;

   localparam int unsigned WIDTH  = 64;
   localparam int unsigned DIGITS = 20;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic [7:0]       out_byte;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out_last;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   result_ascii_tx #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      logic [63:0] value;
      string       text;
      int          lat;   // edges after capture until out_valid is seen
      bit          rnd;   // pseudo-random out_ready
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_text(input string s);
      for (int i = 0; i < s.len(); i++) begin
         exp_q.push_back(s[i]);
      end
      exp_q.push_back(8'h0A);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_byte"},  64'(out_byte), 64'h00);
      chk({tag, "_valid"}, 64'(out_valid), 64'h0);
      chk({tag, "_last"},  64'(out_last), 64'h0);
      chk({tag, "_busy"},  64'(busy), 64'h0);
      chk({tag, "_done"},  64'(done), 64'h0);
   endtask

   // Reset, confirm idle, then present a new answer (next posedge captures it)
   task automatic fresh_start(input logic [63:0] value, input string text);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'h0);
      chk("idle_valid", 64'(out_valid), 64'h0);
      exp_q.delete();
      push_text(text);
      in_data  = value;
      in_valid = 1'b1;
   endtask

   // Capture on the next posedge, measure first-byte latency, drain the stream
   task automatic run_answer(input int lat, input bit rnd, input int abort_after);
      int         n;
      bit         seen;
      bit         prev_stall;
      logic [7:0] prev_byte;
      logic       prev_last;
      int         xfers;
      bit         finished;
      logic [7:0] e;
      @(posedge clk);
      #1;
      chk("capture_busy", 64'(busy), 64'h1);
      chk("capture_valid", 64'(out_valid), 64'h0);
      in_data = {$urandom, $urandom};  // post-capture changes must not matter
      seen = 1'b0;
      for (n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) n = 0;
      chk("first_valid_edge", 64'(n), 64'(lat));
      if (!seen) return;
      prev_stall = 1'b0;
      prev_byte  = 8'h00;
      prev_last  = 1'b0;
      xfers      = 0;
      finished   = 1'b0;
      for (int c = 0; c < 4000 && !finished; c++) begin
         @(negedge clk);
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         chk("valid_held", 64'(out_valid), 64'h1);
         if (prev_stall) begin
            chk("stall_byte", 64'(out_byte), 64'(prev_byte));
            chk("stall_last", 64'(out_last), 64'(prev_last));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_byte: got %0h expected no byte", out_byte);
            end else begin
               e = exp_q.pop_front();
               chk("byte", 64'(out_byte), 64'(e));
               chk("last", 64'(out_last), 64'(e == 8'h0A));
               if (e == 8'h0A) finished = 1'b1;
            end
            xfers++;
         end
         prev_stall = out_valid && !out_ready;
         prev_byte  = out_byte;
         prev_last  = out_last;
         @(posedge clk);
         if (abort_after > 0 && xfers == abort_after) begin
            #2 rst = 1'b1;
            return;
         end
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d bytes expected newline", xfers);
         return;
      end
      #1;
      chk("end_done", 64'(done), 64'h1);
      chk("end_busy", 64'(busy), 64'h0);
      chk("end_valid", 64'(out_valid), 64'h0);
      chk("end_last", 64'(out_last), 64'h0);
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{value: 64'd18,                   text: "18",                   lat: 83, rnd: 1'b0};
      vecs[1] = '{value: 64'd0,                    text: "0",                    lat: 84, rnd: 1'b0};
      vecs[2] = '{value: 64'hFFFF_FFFF_FFFF_FFFF,  text: "18446744073709551615", lat: 65, rnd: 1'b0};
      vecs[3] = '{value: 64'd1006,                 text: "1006",                 lat: 81, rnd: 1'b1};

      for (int v = 0; v < 4; v++) begin
         fresh_start(vecs[v].value, vecs[v].text);
         run_answer(vecs[v].lat, vecs[v].rnd, 0);
         chk("queue_empty", 64'(exp_q.size()), 64'h0);
      end

      // Reset mid-stream after two bytes; in_valid stays high through reset
      fresh_start(64'd12345, "12345");
      run_answer(80, 1'b0, 2);
      #1;
      chk_zero_outputs("abort");
      exp_q.delete();
      push_text("12345");
      in_data = 64'd12345;
      @(negedge clk);
      rst = 1'b0;
      run_answer(80, 1'b0, 0);
      chk("requeue_empty", 64'(exp_q.size()), 64'h0);

      // DONE absorbs further valid results
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         in_data = {$urandom, $urandom};
         chk("hold_valid", 64'(out_valid), 64'h0);
         chk("hold_done", 64'(done), 64'h1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
